// File: rtl/aoc_gf2_pkg.sv
// Shared types and width helpers for the GF(2) solution enumerator and its sinks.
package aoc_gf2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    REPORT
  } sink_state_t;

  function automatic int weight_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gf2_popcount.sv
// Combinational population count of a GF(2) vector; synthesis folds the sum into an adder tree.
module gf2_popcount
  import aoc_gf2_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]           vec,
  output logic [weight_w(WIDTH)-1:0] count
);

  localparam int CW = weight_w(WIDTH);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/min_weight_solution_sink.sv
// Stream sink that keeps the minimum-Hamming-weight solution vector of each packet
// and reports it, with the packet's beat count, on a valid/ready result port.
//
//  state  | meaning
//  IDLE   | waiting for the first beat of a packet, tready high
//  ACCUM  | packet in progress, tracking the running minimum
//  DRAIN  | tlast accepted, waiting for the compare pipeline to retire it
//  REPORT | result_valid high, holding until result_ready
module min_weight_solution_sink
  import aoc_gf2_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VAR_COUNT  = 7,
  parameter int COUNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          solution_stream_tvalid,
  input  logic [DATA_WIDTH-1:0]         solution_stream_tdata,
  input  logic                          solution_stream_tlast,
  output logic                          solution_stream_tready,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [weight_w(VAR_COUNT)-1:0] result_weight,
  output logic [VAR_COUNT-1:0]          result_vector,
  output logic [COUNT_W-1:0]            result_count,
  output logic                          busy
);

  localparam int WW = weight_w(VAR_COUNT);

  sink_state_t state;

  logic                 accept;
  logic                 unused_tdata;

  logic                 beat_valid;
  logic                 beat_last;
  logic                 beat_first;
  logic [VAR_COUNT-1:0] beat_vec;
  logic [WW-1:0]        beat_wt;

  logic                 s1_valid;
  logic                 s1_last;
  logic                 s1_first;
  logic [VAR_COUNT-1:0] s1_vec;
  logic [WW-1:0]        s1_wt;

  logic                 s2_done;
  logic [VAR_COUNT-1:0] min_vec;
  logic [WW-1:0]        min_wt;
  logic [COUNT_W-1:0]   count_r;

  assign accept       = solution_stream_tvalid && solution_stream_tready;
  // Bits above VAR_COUNT are padding from the enumerator and are deliberately dropped.
  assign unused_tdata = ^solution_stream_tdata;

  gf2_popcount #(.WIDTH(VAR_COUNT)) u_popcount (
    .vec  (beat_vec),
    .count(beat_wt)
  );

  // Accept register, stage 1 (masked vector + popcount), stage 2 (running minimum).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_valid <= 1'b0;
      beat_last  <= 1'b0;
      beat_first <= 1'b0;
      beat_vec   <= '0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_first   <= 1'b0;
      s1_vec     <= '0;
      s1_wt      <= '0;
      s2_done    <= 1'b0;
      min_vec    <= '0;
      min_wt     <= '1;
    end else begin
      beat_valid <= accept;
      if (accept) begin
        beat_vec   <= solution_stream_tdata[VAR_COUNT-1:0];
        beat_last  <= solution_stream_tlast;
        beat_first <= (state == IDLE);
      end
      s1_valid <= beat_valid;
      if (beat_valid) begin
        s1_vec   <= beat_vec;
        s1_wt    <= beat_wt;
        s1_last  <= beat_last;
        s1_first <= beat_first;
      end
      s2_done <= s1_valid && s1_last;
      // Strict compare: a tie keeps the earlier vector.
      if (s1_valid && (s1_first || (s1_wt < min_wt))) begin
        min_wt  <= s1_wt;
        min_vec <= s1_vec;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      solution_stream_tready <= 1'b0;
      result_valid           <= 1'b0;
      result_weight          <= '1;
      result_vector          <= '0;
      result_count           <= '0;
      busy                   <= 1'b0;
      count_r                <= '0;
    end else begin
      case (state)
        IDLE: begin
          solution_stream_tready <= 1'b1;
          if (accept) begin
            count_r <= COUNT_W'(1);
            busy    <= 1'b1;
            if (solution_stream_tlast) begin
              state                  <= DRAIN;
              solution_stream_tready <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            if (count_r != {COUNT_W{1'b1}}) count_r <= count_r + COUNT_W'(1);
            if (solution_stream_tlast) begin
              state                  <= DRAIN;
              solution_stream_tready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (s2_done) begin
            state         <= REPORT;
            result_valid  <= 1'b1;
            result_weight <= min_wt;
            result_vector <= min_vec;
            result_count  <= count_r;
          end
        end
        REPORT: begin
          if (result_ready) begin
            state                  <= IDLE;
            result_valid           <= 1'b0;
            solution_stream_tready <= 1'b1;
            busy                   <= 1'b0;
          end
        end
        default: begin
          state                  <= IDLE;
          solution_stream_tready <= 1'b0;
          result_valid           <= 1'b0;
          busy                   <= 1'b0;
        end
      endcase
    end
  end

endmodule
